mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between the multi-cycle RV32 core and a secondary bus master (DMA engine or program loader).
- The CPU port has absolute priority and sees zero added latency, so the core needs no stall logic.
- The secondary port is served through a req/ack handshake, only in cycles where the CPU issues no memory access.
- The arbiter also holds CPU read data stable across the core's WAIT_MEM/WRITE_BACK cycles.

Parameters:
- ADDR_W, 32, byte-address width of both ports and the RAM.
- STARVE_MAX, 16, pending-cycle count at which dma_starve asserts.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  32  CPU store data (already lane-aligned)
- cpu_wmask  in  4  CPU byte write enables; nonzero = write
- cpu_rstrb  in  1  CPU read strobe
- cpu_rdata  out  32  read data to CPU
- dma_req  in  1  secondary request; held with its fields until ack
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  secondary byte address
- dma_wdata  in  32  secondary write data
- dma_wmask  in  4  secondary byte enables (writes only)
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  32  read data, valid with dma_ack, then held
- dma_starve  out  1  request pending for at least STARVE_MAX cycles
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_wmask  out  4  RAM byte write enables
- ram_rstrb  out  1  RAM read strobe
- ram_rdata  in  32  RAM read data, valid the cycle after ram_rstrb

Behaviour:
- CPU access cycle: cpu_rstrb=1 or cpu_wmask!=0.
- In a CPU access cycle, the RAM outputs pass CPU signals combinationally. Otherwise they carry the secondary request if the FSM is in ISSUE. Otherwise ram_rstrb=0, ram_wmask=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
- CPU read data:
  - cpu_rd_d is a register set to cpu_rstrb every cycle.
  - cpu_rdata = cpu_rd_d ? ram_rdata : cpu_rdata_q.
  - cpu_rdata_q <= ram_rdata whenever cpu_rd_d=1.
  - Secondary reads never change cpu_rdata.
- Secondary FSM (IDLE, ISSUE, DONE):
  - IDLE: when dma_req=1, go to ISSUE next cycle.
  - ISSUE: in a non-CPU cycle, drive the secondary access on the RAM outputs (rstrb = !dma_we; wmask = dma_we ? dma_wmask : 0) and go to DONE. In a CPU cycle, stay in ISSUE and drive nothing for the secondary port.
  - DONE: dma_ack=1 for exactly one cycle. For reads, dma_rdata <= ram_rdata is registered at the end of DONE and is also driven combinationally during DONE, then held. Next state is IDLE. dma_req is not sampled in DONE.
- Latency: minimum 3 cycles from req rise to ack (IDLE, ISSUE, DONE). Each CPU-occupied ISSUE cycle adds one cycle.
- Starvation:
  - 5-bit saturating counter increments each cycle the FSM stays in ISSUE; cleared in IDLE.
  - dma_starve = (count >= STARVE_MAX). Status only; CPU priority is never overridden.
- Simultaneous events:
  - CPU access and ISSUE in the same cycle: CPU wins.
  - CPU read issued in DONE: legal, since ram_rdata in DONE belongs to the secondary read.
  - Same-address accesses are ordered by RAM issue cycle.
- dma_req dropping while in ISSUE is a protocol violation. It is not checked; the request completes anyway.
- Reset (async, any state):
  - FSM -> IDLE; counter 0; cpu_rd_d=0.
  - cpu_rdata_q=0, dma_rdata=0, dma_ack=0, dma_starve=0.
  - RAM strobe and mask = 0.
  - An in-flight secondary transaction is dropped with no ack.

Test Plan:
- Idle CPU; dma read at 0x40 where RAM holds 0xDEADBEEF -> ram_rstrb in cycle 2, dma_ack in cycle 3 with dma_rdata=0xDEADBEEF, held afterwards.
- CPU fetch at 0x0 (RAM 0x00000013), then dma read at 0x40 on the next cycle -> cpu_rdata stays 0x00000013 through 3 following cycles.
- CPU strobing for 4 consecutive cycles while a dma write of 0x12345678, mask 0xF, to 0x80 is pending -> write issues in the 1st free cycle; ack one cycle later; a later CPU read of 0x80 returns 0x12345678.
- dma write, mask 0x2, data 0x0000AB00, to a word holding 0x11223344 -> word reads 0x1122AB44.
- CPU strobing continuously for 20 cycles with a dma request pending, STARVE_MAX=16 -> dma_starve rises after 16 cycles in ISSUE and clears once IDLE is re-entered after the ack.
- rstn low while in ISSUE -> no ack, all outputs 0; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port synchronous RAM between the CPU and a secondary master.
// The CPU always wins and sees no added latency. The secondary port only gets cycles the CPU leaves idle.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wmask,
  input  logic              cpu_rstrb,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_wmask,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              dma_starve,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wmask,
  output logic              ram_rstrb,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STARVE_TH = 5'(STARVE_MAX);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  state_t      state;
  logic [4:0]  starve_cnt;
  logic        op_rd;
  logic        cpu_rd_d;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;
  logic        cpu_access;
  logic        dma_issue;

  assign cpu_access = cpu_rstrb | (|cpu_wmask);
  assign dma_issue  = (state == ISSUE) && !cpu_access;

  // RAM port mux. While reset is held, strobe and mask are forced low so nothing reaches the RAM.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_wmask = 4'b0000;
    ram_rstrb = 1'b0;
    if (!rstn) begin
      ram_wmask = 4'b0000;
      ram_rstrb = 1'b0;
    end else if (cpu_access) begin
      ram_wmask = cpu_wmask;
      ram_rstrb = cpu_rstrb;
    end else if (dma_issue) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_rstrb = !dma_we;
      ram_wmask = dma_we ? dma_wmask : 4'b0000;
    end
  end

  // Secondary handshake: dma_req rises with its fields and stays asserted until dma_ack.
  // dma_ack is a single-cycle pulse, and read data is valid with it.
  // dma_req is ignored in the ack cycle, so the master may drop it there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      starve_cnt  <= 5'd0;
      op_rd       <= 1'b0;
      dma_ack     <= 1'b0;
      dma_rdata_q <= 32'd0;
    end else begin
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          starve_cnt <= 5'd0;
          if (dma_req) state <= ISSUE;
        end
        ISSUE: begin
          if (cpu_access) begin
            if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 5'd1;
          end else begin
            state   <= DONE;
            dma_ack <= 1'b1;
            op_rd   <= !dma_we;
          end
        end
        DONE: begin
          // Clear on the way out so dma_starve is already low in the first IDLE cycle.
          state      <= IDLE;
          starve_cnt <= 5'd0;
          if (op_rd) dma_rdata_q <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CPU read data is live for one cycle after the strobe. It is then held so the core can consume it later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rd_d    <= 1'b0;
      cpu_rdata_q <= 32'd0;
    end else begin
      cpu_rd_d <= cpu_rstrb;
      if (cpu_rd_d) cpu_rdata_q <= ram_rdata;
    end
  end

  assign cpu_rdata  = cpu_rd_d ? ram_rdata : cpu_rdata_q;
  assign dma_rdata  = ((state == DONE) && op_rd) ? ram_rdata : dma_rdata_q;
  assign dma_starve = (starve_cnt >= STARVE_TH);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM, CPU and DMA drivers, and a cycle-level monitor.
// The monitor checks the DUT against a shadow memory and request-timing rules kept in this bench.
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 16;
  localparam int LOG_N      = 16384;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wmask;
  logic              cpu_rstrb;
  logic [31:0]       cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic [3:0]        dma_wmask;
  logic              dma_ack;
  logic [31:0]       dma_rdata;
  logic              dma_starve;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wmask;
  logic              ram_rstrb;
  logic [31:0]       ram_rdata = 32'd0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rstrb(cpu_rstrb), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wmask(dma_wmask), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .dma_starve(dma_starve),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_rstrb(ram_rstrb), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model and shadow memory ----------------
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_load = 1'b0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      if (ram_rstrb) ram_rdata <= mem[ram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          r;
  } dma_item_t;

  dma_item_t   dma_q[$];
  logic [31:0] cpu_exp_q[$];
  logic [31:0] cpu_hold = 32'd0;
  logic [31:0] dma_hold = 32'd0;
  bit          busy_log [0:LOG_N-1];
  bit          rd_log   [0:LOG_N-1];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] wm);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (wm[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  function automatic bit all_busy(int a, int b);
    for (int i = a; i <= b; i++) if (!busy_log[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int first_free(int a, int b);
    for (int i = a; i <= b; i++) if (!busy_log[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_rstrb = 1'b0;
    cpu_wmask = 4'h0;
  endtask

  task automatic cpu_cycle(input bit rd, input logic [3:0] wm, input logic [31:0] addr,
                           input logic [31:0] wd);
    int w = int'(addr[9:2]);
    cpu_rstrb = rd;
    cpu_wmask = wm;
    cpu_addr  = addr;
    cpu_wdata = wd;
    if (rd) cpu_exp_q.push_back(ref_mem[w]);
    ref_mem[w] = merge(ref_mem[w], wd, wm);
    next_cycle();
  endtask

  task automatic dma_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wm);
    dma_item_t it;
    bit got;
    int w = int'(addr[9:2]);
    it.rd    = !we;
    it.addr  = addr;
    it.wdata = wd;
    it.wmask = we ? wm : 4'h0;
    it.rdata = ref_mem[w];
    it.r     = cyc;
    if (we) ref_mem[w] = merge(ref_mem[w], wd, wm);
    dma_q.push_back(it);
    dma_we = we; dma_addr = addr; dma_wdata = wd; dma_wmask = wm;
    dma_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      next_cycle();
      got = dma_ack;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL dma_timeout: got no ack expected ack within 200 cycles (addr %0h)", addr);
      dma_q.delete();
    end
    dma_req = 1'b0;
    next_cycle();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    bit          busy, have, exp_ack;
    dma_item_t   it;
    logic [36:0] exp_bus;
    logic [31:0] exp_wd;
    int          f, cnt;
    if (!rstn) begin
      cpu_exp_q.delete();
      dma_q.delete();
      cpu_hold = 32'd0;
      dma_hold = 32'd0;
      if (cyc < LOG_N) begin busy_log[cyc] = 1'b0; rd_log[cyc] = 1'b0; end
      check("reset_outputs", {dma_ack, dma_starve, ram_rstrb, ram_wmask, cpu_rdata, dma_rdata}, '0);
    end else begin
      busy = cpu_rstrb || (cpu_wmask != 4'h0);
      if (cyc < LOG_N) begin busy_log[cyc] = busy; rd_log[cyc] = cpu_rstrb; end
      if (cyc > 0 && rd_log[cyc-1]) begin
        if (cpu_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cpu_rdata_missing @cycle %0d: got a read with no expected value", cyc);
        end else cpu_hold = cpu_exp_q.pop_front();
      end
      check("cpu_rdata", cpu_rdata, cpu_hold);

      have = (dma_q.size() != 0);
      if (have) it = dma_q[0];
      exp_bus = {1'b0, 4'h0, cpu_addr};
      exp_wd  = cpu_wdata;
      if (busy) exp_bus = {cpu_rstrb, cpu_wmask, cpu_addr};
      else if (have && cyc >= it.r + 1 && all_busy(it.r + 1, cyc - 1)) begin
        exp_bus = {it.rd, it.wmask, it.addr};
        exp_wd  = it.wdata;
      end
      check("ram_bus", {ram_rstrb, ram_wmask, ram_addr}, exp_bus);
      if (exp_bus[35:32] != 4'h0) check("ram_wdata", ram_wdata, exp_wd);

      cnt = 0;
      if (have && cyc > it.r) begin
        f   = first_free(it.r + 1, cyc - 1);
        cnt = (f >= 0) ? f - (it.r + 1) : cyc - (it.r + 1);
      end
      check("dma_starve", dma_starve, (cnt >= STARVE_MAX));

      exp_ack = have && cyc >= it.r + 2 && !busy_log[cyc-1] && all_busy(it.r + 1, cyc - 2);
      check("dma_ack", dma_ack, exp_ack);
      if (exp_ack) begin
        void'(dma_q.pop_front());
        if (it.rd) dma_hold = it.rdata;
      end
      check("dma_rdata", dma_rdata, dma_hold);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    rstn = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wmask = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[0]  = 32'h0000_0013;
    ref_mem[16] = 32'hDEAD_BEEF;
    ref_mem[48] = 32'h1122_3344;
    mem_load = 1'b1;
    // Strobe and write during reset: none of it may reach the RAM.
    cpu_rstrb = 1'b1; cpu_wmask = 4'hF; cpu_addr = 32'h3C0; cpu_wdata = $urandom;
    repeat (3) next_cycle();
    mem_load = 1'b0;
    cpu_idle();
    next_cycle();
    rstn = 1'b1;
    repeat (2) next_cycle();

    // DMA read with the CPU idle
    dma_xfer(1'b0, 32'h40, 32'h0, 4'hF);
    repeat (2) next_cycle();

    // CPU fetch followed by a DMA read: the CPU data must hold
    cpu_cycle(1'b1, 4'h0, 32'h0, 32'h0);
    cpu_idle();
    dma_xfer(1'b0, 32'h40, 32'h0, 4'h0);
    repeat (3) next_cycle();

    // DMA write pending while the CPU strobes for 4 cycles
    fork
      dma_xfer(1'b1, 32'h80, 32'h1234_5678, 4'hF);
      begin
        repeat (4) cpu_cycle(1'b1, 4'h0, 32'h10, 32'h0);
        cpu_idle();
      end
    join
    cpu_cycle(1'b1, 4'h0, 32'h80, 32'h0);
    cpu_idle();
    next_cycle();

    // Partial-lane DMA write, then readback by both masters
    dma_xfer(1'b1, 32'hC0, 32'h0000_AB00, 4'h2);
    dma_xfer(1'b0, 32'hC0, 32'h0, 4'h0);
    cpu_cycle(1'b1, 4'h0, 32'hC0, 32'h0);
    cpu_idle();
    next_cycle();

    // Starvation: CPU busy for 20 cycles
    fork
      dma_xfer(1'b0, 32'h104, 32'h0, 4'h0);
      begin
        repeat (20) cpu_cycle(1'b1, 4'h0, 32'($urandom_range(0, 31) << 2), 32'h0);
        cpu_idle();
      end
    join
    repeat (2) next_cycle();

    // Reset asserted while the request waits in ISSUE
    begin : rst_in_issue
      dma_item_t it;
      it.rd = 1'b1; it.addr = 32'h108; it.wdata = '0; it.wmask = '0;
      it.rdata = ref_mem[66]; it.r = cyc;
      dma_q.push_back(it);
      dma_we = 1'b0; dma_addr = 32'h108; dma_req = 1'b1;
      repeat (5) cpu_cycle(1'b1, 4'h0, 32'h20, 32'h0);
      rstn = 1'b0;
      dma_req = 1'b0;
      repeat (3) next_cycle();
      cpu_idle();
      next_cycle();
      rstn = 1'b1;
      next_cycle();
      dma_xfer(1'b0, 32'h108, 32'h0, 4'h0);
    end

    // Randomized traffic on disjoint CPU and DMA regions
    fork
      begin : cpu_rand
        for (int i = 0; i < 300; i++) begin
          k = $urandom_range(0, 39);
          if (k == 0) begin
            repeat (18) cpu_cycle(1'b1, 4'h0, 32'($urandom_range(0, 31) << 2), 32'h0);
          end else if (k < 20) cpu_cycle(1'b1, 4'h0, 32'($urandom_range(0, 31) << 2), 32'h0);
          else if (k < 28) cpu_cycle(1'b0, 4'($urandom_range(1, 15)),
                                     32'($urandom_range(0, 31) << 2), $urandom);
          else begin
            cpu_idle();
            next_cycle();
          end
        end
        cpu_idle();
      end
      begin : dma_rand
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 4)) next_cycle();
          dma_xfer(1'($urandom_range(0, 1)), 32'($urandom_range(64, 127) << 2), $urandom,
                   4'($urandom_range(1, 15)));
        end
      end
    join
    repeat (5) next_cycle();
    check("cpu_queue_drained", cpu_exp_q.size(), 0);
    check("dma_queue_drained", dma_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_err++;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
